regfile_multiport: RTL and testbench

- Parametrised successor to the 8x8, 1-write/2-read datapath register file.
- Generalised in data width and depth. Adds write-to-read bypass, a sequential background clear engine with busy/done status, and dropped-write reporting.
- Sits between the datapath function unit (write side) and the operand buses A/B of the single-cycle CPU lab.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_multiport_if.sv | 29 ++
 rtl/regfile_read_port.sv | 30 +++
 rtl/regfile_multiport.sv | 110 +++++++++++
 tb/tb_regfile_multiport.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  typedef enum logic {
    IDLE,
    CLEARING
  } state_e;

  // Forward write data to a read port when the accepted write targets the same address.
  function automatic logic bypass_sel(input logic        bypass_en,
                                      input logic        wr_accept,
                                      input logic [31:0] waddr,
                                      input logic [31:0] raddr);
    return bypass_en && wr_accept && (waddr == raddr);
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: write side, two read ports, clear/status.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic [DATA_W-1:0] Data;
  logic [ADDR_W-1:0] DA;
  logic              RW;
  logic [ADDR_W-1:0] AA;
  logic [ADDR_W-1:0] BA;
  logic              clear;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              busy;
  logic              done;
  logic              wr_drop;

  modport master (
    output Data, DA, RW, AA, BA, clear,
    input  A, B, busy, done, wr_drop
  );

  modport slave (
    input  Data, DA, RW, AA, BA, clear,
    output A, B, busy, done, wr_drop
  );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port with optional write-to-read forwarding.
// REGFILE_ZERO_REG_EN: address 0 always reads zero.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic                               wr_accept,
  output logic [DATA_W-1:0]                  rdata
);

  always_comb begin
    rdata = regs[raddr];
    if (bypass_sel(BYPASS != 0, wr_accept, 32'(waddr), 32'(raddr))) begin
      rdata = wdata;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (raddr == '0) begin
      rdata = '0;
    end
`endif
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised 1-write/2-read register file with bypass, background clear and drop reporting.
// REGFILE_ZERO_REG_EN: register 0 hardwired to zero, writes to it silently discarded.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_multiport_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            cnt_q, cnt_d;
  logic                         done_q, done_d;
  logic                         wr_drop_q, wr_drop_d;
  logic                         wr_addr_ok;
  logic                         wr_accept;

  // Writes to a hardwired register are discarded, not reported as drops.
  always_comb begin
    wr_addr_ok = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
    wr_addr_ok = (bus.DA != '0);
`endif
    wr_accept = bus.RW && (state_q == IDLE) && wr_addr_ok;
    wr_drop_d = bus.RW && (state_q == CLEARING) && wr_addr_ok;
  end

  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (wr_accept) begin
      regs_d[bus.DA] = bus.Data;
    end
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
`ifdef REGFILE_ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign bus.busy    = (state_q == CLEARING);
  assign bus.done    = done_q;
  assign bus.wr_drop = wr_drop_q;

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .regs      (regs_q),
    .raddr     (bus.AA),
    .waddr     (bus.DA),
    .wdata     (bus.Data),
    .wr_accept (wr_accept),
    .rdata     (bus.A)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .regs      (regs_q),
    .raddr     (bus.BA),
    .waddr     (bus.DA),
    .wdata     (bus.Data),
    .wr_accept (wr_accept),
    .rdata     (bus.B)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: dut0 with BYPASS=1, dut1 with BYPASS=0, shared stimulus.
module tb_regfile_multiport;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZR = 1'b1;
`else
  localparam logic ZR = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [7:0] val;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Data;
  logic [2:0] DA, AA, BA;
  logic       RW, clear;

  item_t exp_q[$];
  item_t got_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  regfile_multiport_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  regfile_multiport_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  assign bus0.Data = Data;  assign bus1.Data = Data;
  assign bus0.DA = DA;      assign bus1.DA = DA;
  assign bus0.RW = RW;      assign bus1.RW = RW;
  assign bus0.AA = AA;      assign bus1.AA = AA;
  assign bus0.BA = BA;      assign bus1.BA = BA;
  assign bus0.clear = clear; assign bus1.clear = clear;

  regfile_multiport #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  regfile_multiport #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    RW = 1'b1; DA = a; Data = d;
    tick();
    RW = 1'b0;
  endtask

  task automatic test_reset();
    item_t e, g;
    reset = 1'b1; RW = 1'b0; clear = 1'b0; Data = '0; DA = '0; AA = '0; BA = '0;
    tick(); tick();
    reset = 1'b0;
    exp_q.push_back('{"rst_busy", 8'h00});
    exp_q.push_back('{"rst_done", 8'h00});
    exp_q.push_back('{"rst_wr_drop", 8'h00});
    got_q.push_back('{"rst_busy", {7'b0, bus0.busy}});
    got_q.push_back('{"rst_done", {7'b0, bus0.done}});
    got_q.push_back('{"rst_wr_drop", {7'b0, bus0.wr_drop}});
    for (int i = 0; i < 8; i++) begin
      AA = 3'(i); BA = 3'(7 - i);
      exp_q.push_back('{"rst_a", 8'h00});
      exp_q.push_back('{"rst_b", 8'h00});
      #1;
      got_q.push_back('{"rst_a", bus0.A});
      got_q.push_back('{"rst_b", bus1.B});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
  endtask

  task automatic test_write_read();
    item_t e, g;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'((i + 1) * 17));
    AA = 3'd3; BA = 3'd6;
    exp_q.push_back('{"rd_a3_bp", 8'h44}); exp_q.push_back('{"rd_b6_bp", 8'h77});
    exp_q.push_back('{"rd_a3_nb", 8'h44}); exp_q.push_back('{"rd_b6_nb", 8'h77});
    #1;
    got_q.push_back('{"rd_a3_bp", bus0.A}); got_q.push_back('{"rd_b6_bp", bus0.B});
    got_q.push_back('{"rd_a3_nb", bus1.A}); got_q.push_back('{"rd_b6_nb", bus1.B});
    AA = 3'd5; BA = 3'd5;
    exp_q.push_back('{"rd_same_a", 8'h66}); exp_q.push_back('{"rd_same_b", 8'h66});
    #1;
    got_q.push_back('{"rd_same_a", bus0.A}); got_q.push_back('{"rd_same_b", bus0.B});
    AA = 3'd0;
    exp_q.push_back('{"rd_r0", ZR ? 8'h00 : 8'h11});
    #1;
    got_q.push_back('{"rd_r0", bus0.A});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
  endtask

  task automatic test_bypass();
    item_t e, g;
    wr(3'd2, 8'h10);
    RW = 1'b1; DA = 3'd2; Data = 8'hAB; AA = 3'd2; BA = 3'd2;
    exp_q.push_back('{"byp_a_on", 8'hAB});  exp_q.push_back('{"byp_b_on", 8'hAB});
    exp_q.push_back('{"byp_a_off", 8'h10}); exp_q.push_back('{"byp_b_off", 8'h10});
    #1;
    got_q.push_back('{"byp_a_on", bus0.A});  got_q.push_back('{"byp_b_on", bus0.B});
    got_q.push_back('{"byp_a_off", bus1.A}); got_q.push_back('{"byp_b_off", bus1.B});
    BA = 3'd3;
    exp_q.push_back('{"byp_other_addr", 8'h44});
    #1;
    got_q.push_back('{"byp_other_addr", bus0.B});
    tick();
    RW = 1'b0;
    exp_q.push_back('{"byp_next_on", 8'hAB}); exp_q.push_back('{"byp_next_off", 8'hAB});
    #1;
    got_q.push_back('{"byp_next_on", bus0.A}); got_q.push_back('{"byp_next_off", bus1.A});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
  endtask

  task automatic test_clear();
    item_t e, g;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    clear = 1'b1;
    tick();
    clear = 1'b0; AA = 3'd0; BA = 3'd7;
    // Sample c lies in busy cycle c+1; the edge ending busy cycle k clears register k-1.
    for (int c = 0; c < 10; c++) begin
      exp_q.push_back('{"clr_busy", {7'b0, c < 8}});
      exp_q.push_back('{"clr_done", {7'b0, c == 8}});
      exp_q.push_back('{"clr_r0", (ZR || c >= 1) ? 8'h00 : 8'hFF});
      exp_q.push_back('{"clr_r7", (c >= 8) ? 8'h00 : 8'hFF});
      #1;
      got_q.push_back('{"clr_busy", {7'b0, bus0.busy}});
      got_q.push_back('{"clr_done", {7'b0, bus0.done}});
      got_q.push_back('{"clr_r0", bus0.A});
      got_q.push_back('{"clr_r7", bus0.B});
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      AA = 3'(i);
      exp_q.push_back('{"clr_all_zero", 8'h00});
      #1;
      got_q.push_back('{"clr_all_zero", bus1.A});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
  endtask

  task automatic test_drop();
    item_t e, g;
    logic  seen_done, saw_5a;
    wr(3'd7, 8'h21);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick();
    RW = 1'b1; DA = 3'd7; Data = 8'h5A; AA = 3'd7;
    exp_q.push_back('{"drop_no_byp", 8'h21}); exp_q.push_back('{"drop_no_byp_nb", 8'h21});
    #1;
    got_q.push_back('{"drop_no_byp", bus0.A}); got_q.push_back('{"drop_no_byp_nb", bus1.A});
    tick();
    RW = 1'b0;
    exp_q.push_back('{"drop_flag", 8'h01}); exp_q.push_back('{"drop_r7_kept", 8'h21});
    got_q.push_back('{"drop_flag", {7'b0, bus0.wr_drop}}); got_q.push_back('{"drop_r7_kept", bus0.A});
    tick();
    exp_q.push_back('{"drop_flag_clr", 8'h00});
    got_q.push_back('{"drop_flag_clr", {7'b0, bus0.wr_drop}});
    seen_done = 1'b0; saw_5a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus0.A === 8'h5A) saw_5a = 1'b1;
      if (bus0.done === 1'b1) begin seen_done = 1'b1; break; end
      tick();
    end
    exp_q.push_back('{"drop_done_seen", 8'h01}); exp_q.push_back('{"drop_never_5a", 8'h00});
    exp_q.push_back('{"drop_r7_zero", 8'h00});
    #1;
    got_q.push_back('{"drop_done_seen", {7'b0, seen_done}});
    got_q.push_back('{"drop_never_5a", {7'b0, saw_5a}});
    got_q.push_back('{"drop_r7_zero", bus0.A});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    item_t e, g;
    for (int i = 1; i < 8; i++) wr(3'(i), 8'hC3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back('{"rmc_busy", 8'h00}); exp_q.push_back('{"rmc_done", 8'h00});
    got_q.push_back('{"rmc_busy", {7'b0, bus0.busy}}); got_q.push_back('{"rmc_done", {7'b0, bus0.done}});
    for (int i = 0; i < 8; i++) begin
      AA = 3'(i);
      exp_q.push_back('{"rmc_zero", 8'h00});
      #1;
      got_q.push_back('{"rmc_zero", bus0.A});
    end
    tick();
    exp_q.push_back('{"rmc_no_done", 8'h00});
    got_q.push_back('{"rmc_no_done", {7'b0, bus0.done}});
    wr(3'd4, 8'h33);
    AA = 3'd4;
    exp_q.push_back('{"rmc_wr_r4", 8'h33});
    #1;
    got_q.push_back('{"rmc_wr_r4", bus0.A});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    item_t e, g;
    logic  seen_done;
    clear = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    exp_q.push_back('{"b2b_done", 8'h01}); exp_q.push_back('{"b2b_gap", 8'h00});
    got_q.push_back('{"b2b_done", {7'b0, bus0.done}}); got_q.push_back('{"b2b_gap", {7'b0, bus0.busy}});
    tick();
    clear = 1'b0;
    exp_q.push_back('{"b2b_restart", 8'h01}); exp_q.push_back('{"b2b_done_low", 8'h00});
    got_q.push_back('{"b2b_restart", {7'b0, bus0.busy}}); got_q.push_back('{"b2b_done_low", {7'b0, bus0.done}});
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus0.done === 1'b1) begin seen_done = 1'b1; break; end
      tick();
    end
    exp_q.push_back('{"b2b_second_done", 8'h01});
    got_q.push_back('{"b2b_second_done", {7'b0, seen_done}});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
    tick();
  endtask

  task automatic test_zero_reg();
    item_t e, g;
    RW = 1'b1; DA = 3'd0; Data = 8'h99; AA = 3'd0;
    exp_q.push_back('{"r0_same_bp", ZR ? 8'h00 : 8'h99});
    exp_q.push_back('{"r0_same_nb", 8'h00});
    #1;
    got_q.push_back('{"r0_same_bp", bus0.A}); got_q.push_back('{"r0_same_nb", bus1.A});
    tick();
    RW = 1'b0;
    exp_q.push_back('{"r0_next", ZR ? 8'h00 : 8'h99});
    exp_q.push_back('{"r0_wr_drop", 8'h00});
    #1;
    got_q.push_back('{"r0_next", bus0.A}); got_q.push_back('{"r0_wr_drop", {7'b0, bus0.wr_drop}});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL %s: no sample, required %h", e.tag, e.val); end
      else begin
        g = got_q.pop_front();
        if (g.val !== e.val) begin n_fail++; $display("FAIL %s: got %h required %h", e.tag, g.val, e.val); end
      end
    end
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_drop();
    test_reset_mid_clear();
    test_back_to_back();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
